// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] F_MULT = 4'b1010;
  localparam logic [3:0] F_DIV  = 4'b1011;
  localparam logic [3:0] F_MTHI = 4'b1100;
  localparam logic [3:0] F_MTLO = 4'b1101;

  // LO result for a divide by zero; sliced to WIDTH by the user.
  localparam logic [63:0] DIV0_LO = '1;

endpackage

// File: rtl/muldiv_unit_divstep.sv
// One restoring-division step: shift in a dividend bit, subtract if it fits.
module divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             din_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sh    = {rem_i, din_i};
    // When the subtract is taken the result is below the divisor, so the low bits suffice.
    diff  = sh[WIDTH-1:0] - dvs_i;
    q_o   = (sh >= {1'b0, dvs_i});
    rem_o = q_o ? diff : sh[WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned mult/div with HI/LO; MULDIV_FAST_MULT_EN makes mult single-cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       f,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hilo_rd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             div_q, div_d;

  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] rem_nxt;
  logic             qbit;
`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
`endif

  // Divide: acc is the partial remainder, a shifts out dividend bits and collects quotient bits.
  divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_i (acc_q),
    .din_i (a_q[WIDTH-1]),
    .dvs_i (b_q),
    .rem_o (rem_nxt),
    .q_o   (qbit)
  );

  // Multiply: acc is the product high half, b shifts out multiplier bits and collects the low half.
  assign msum = {1'b0, acc_q} + ({(WIDTH+1){b_q[0]}} & {1'b0, a_q});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULDIV_FAST_MULT_EN
    fast_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif
    case (state_q)
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (div_q) begin
          acc_d = rem_nxt;
          a_d   = {a_q[WIDTH-2:0], qbit};
        end else begin
          acc_d = msum[WIDTH:1];
          b_d   = {msum[0], b_q[WIDTH-1:1]};
        end
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(WIDTH-1)) begin
          state_d = DONE;
          hi_d    = acc_d;
          if (div_q) lo_d = (b_q == '0) ? DIV0_LO[WIDTH-1:0] : a_d;
          else       lo_d = b_d;
        end
      end
      default: begin
        state_d = IDLE;
        if (start && !flush) begin
          case (f)
            F_MULT, F_DIV: begin
`ifdef MULDIV_FAST_MULT_EN
              if (f == F_MULT) begin
                {hi_d, lo_d} = fast_prod;
                state_d      = DONE;
              end else
`endif
              begin
                a_d     = a;
                b_d     = b;
                acc_d   = '0;
                cnt_d   = '0;
                div_d   = (f == F_DIV);
                state_d = RUN;
              end
            end
            F_MTHI:  hi_d = a;
            F_MTLO:  lo_d = a;
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign stall = busy & (hilo_rd | start);

endmodule
